// File: rtl/tanh_backward.sv
// Tanh backward pass: dx = g * (1 - y*y) in fixed point, computed LANES elements per cycle.
// Define TANH_BACKWARD_ROUND_EN to round half-up on both fixed-point shifts (default: floor).
module tanh_backward #(
    parameter int DATA_WIDTH = 11,
    parameter int SA_LENGTH  = 256,
    parameter int S          = 7,
    parameter int LANES      = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic signed [DATA_WIDTH*SA_LENGTH-1:0] y,
    input  logic signed [DATA_WIDTH*SA_LENGTH-1:0] g,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic signed [DATA_WIDTH*SA_LENGTH-1:0] dx,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   busy
);

    localparam int N  = SA_LENGTH / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2*DATA_WIDTH + 2;
    localparam logic signed [PW-1:0] ONE = PW'(2**S);
`ifdef TANH_BACKWARD_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(2**(S-1));
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                           state, next_state;
    logic [CW-1:0]                    cnt;
    logic [DATA_WIDTH*SA_LENGTH-1:0]  y_buf, g_buf;
    logic signed [DATA_WIDTH-1:0]     lane_dx [LANES];

    // d = 1 - y^2 is clamped to [0, 1] so the final product always fits DATA_WIDTH
    function automatic logic signed [DATA_WIDTH-1:0] grad(
        input logic signed [DATA_WIDTH-1:0] yv,
        input logic signed [DATA_WIDTH-1:0] gv
    );
        logic signed [PW-1:0] ye, ge, p, d, prod;
        ye   = PW'(yv);
        ge   = PW'(gv);
        p    = (ye * ye + RND) >>> S;
        d    = ONE - p;
        if (d < 0)
            d = '0;
        else if (d > ONE)
            d = ONE;
        prod = (ge * d + RND) >>> S;
        return prod[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            int idx;
            idx        = int'(cnt) * LANES + l;
            lane_dx[l] = grad(y_buf[idx*DATA_WIDTH +: DATA_WIDTH],
                              g_buf[idx*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // in_ready only in IDLE, so an output handshake never overlaps a new accept
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    next_state = COMPUTE;
            end
            COMPUTE: begin
                busy = 1'b1;
                if (cnt == CW'(N-1))
                    next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            y_buf <= '0;
            g_buf <= '0;
            dx    <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                y_buf <= y;
                g_buf <= g;
                cnt   <= '0;
            end
            if (state == COMPUTE) begin
                for (int l = 0; l < LANES; l++)
                    dx[(int'(cnt)*LANES + l)*DATA_WIDTH +: DATA_WIDTH] <= lane_dx[l];
                if (cnt == CW'(N-1))
                    cnt <= '0;
                else
                    cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
